// File: rtl/bram_pipelined_if.sv
// Access bundle for bram_pipelined: write port, read port and clear/busy control.
// The master drives the requests; the slave (the RAM) returns busy and the read data.
interface bram_pipelined_if #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned LOG2_DEPTH = 9
);
  localparam int unsigned NBYTES = WIDTH / 8;

  logic                  clear;
  logic                  busy;
  logic                  we;
  logic [LOG2_DEPTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [NBYTES-1:0]     wbe;
  logic                  re;
  logic [LOG2_DEPTH-1:0] raddr;
  logic                  rvalid;
  logic [WIDTH-1:0]      rdata;

  modport master (
    output clear, we, waddr, wdata, wbe, re, raddr,
    input  busy, rvalid, rdata
  );

  modport slave (
    input  clear, we, waddr, wdata, wbe, re, raddr,
    output busy, rvalid, rdata
  );
endinterface

// File: rtl/bram_pipelined.sv
// Simple dual-port RAM: byte-enable writes, 1- or 2-cycle read latency and a zero-fill clear engine.
// Define BRAM_RDW_BYPASS_EN to return the newly written word on same-address read/write; otherwise read-first.
module bram_pipelined #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned LOG2_DEPTH   = 9,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  bram_pipelined_if.slave   bus
);

  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam logic [LOG2_DEPTH-1:0] LAST_ADDR = LOG2_DEPTH'(DEPTH - 1);

  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("bram_pipelined: WIDTH must be a multiple of 8");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("bram_pipelined: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LOG2_DEPTH-1:0] r_clr_cnt;
  logic [LOG2_DEPTH-1:0] w_clr_cnt_nxt;

  logic                  w_busy;
  logic                  w_clr_we;
  logic                  w_wr_en;
  logic                  w_rd_en;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      w_rd_word;

  logic                  r_vld1;
  logic [WIDTH-1:0]      r_data1;

  // Clear FSM: state register (reset starts a full zero-fill pass)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Clear FSM: next state; a clear request during a pass is ignored
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.clear) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + LOG2_DEPTH'(1);
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // Clear FSM: outputs; user accesses are gated off for the whole pass
  always_comb begin
    w_busy   = 1'b0;
    w_clr_we = 1'b0;
    if (r_state == S_CLEAR) begin
      w_busy   = 1'b1;
      w_clr_we = 1'b1;
    end
    w_wr_en = bus.we & ~w_busy;
    w_rd_en = bus.re & ~w_busy;
  end

  assign bus.busy = w_busy;

  // Array write port: clear engine has exclusive use while running
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.wbe[b]) begin
          r_mem[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef BRAM_RDW_BYPASS_EN
  // Same-address collision returns the merged new word
  always_comb begin
    w_rd_word = r_mem[bus.raddr];
    if (w_wr_en && (bus.waddr == bus.raddr)) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.wbe[b]) begin
          w_rd_word[8*b +: 8] = bus.wdata[8*b +: 8];
        end
      end
    end
  end
`else
  // Read-first: the old contents are returned on a collision
  always_comb begin
    w_rd_word = r_mem[bus.raddr];
  end
`endif

  // First read stage; data holds when no read is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld1  <= 1'b0;
      r_data1 <= '0;
    end else begin
      r_vld1 <= w_rd_en;
      if (w_rd_en) begin
        r_data1 <= w_rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             r_vld2;
    logic [WIDTH-1:0] r_data2;

    // Extra output register stage
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_vld2  <= 1'b0;
        r_data2 <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_data2 <= r_data1;
        end
      end
    end

    assign bus.rvalid = r_vld2;
    assign bus.rdata  = r_data2;
  end else begin : g_lat1
    assign bus.rvalid = r_vld1;
    assign bus.rdata  = r_data1;
  end

endmodule

// File: tb/tb_bram_pipelined.sv
// Scoreboard bench: one stimulus stream drives a READ_LATENCY=1 and a READ_LATENCY=2 instance
// (LOG2_DEPTH=4); a monitor thread checks every rvalid against queued expectations and arrival cycle.
module tb_bram_pipelined;

  localparam int unsigned W  = 64;
  localparam int unsigned LD = 4;

`ifdef BRAM_RDW_BYPASS_EN
  localparam logic [63:0] RDW_EXP = 64'hFF;
`else
  localparam logic [63:0] RDW_EXP = 64'h00;
`endif

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t q1[$];
  exp_t q2[$];

  bram_pipelined_if #(.WIDTH(W), .LOG2_DEPTH(LD)) bus1 ();
  bram_pipelined_if #(.WIDTH(W), .LOG2_DEPTH(LD)) bus2 ();

  bram_pipelined #(.WIDTH(W), .LOG2_DEPTH(LD), .READ_LATENCY(1)) u_dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1.slave)
  );

  bram_pipelined #(.WIDTH(W), .LOG2_DEPTH(LD), .READ_LATENCY(2)) u_dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input bit we_, input int wa, input logic [63:0] wd, input logic [7:0] be,
                       input bit re_, input int ra, input bit clr);
    bus1.we = we_;  bus1.waddr = LD'(wa); bus1.wdata = wd; bus1.wbe = be;
    bus1.re = re_;  bus1.raddr = LD'(ra); bus1.clear = clr;
    bus2.we = we_;  bus2.waddr = LD'(wa); bus2.wdata = wd; bus2.wbe = be;
    bus2.re = re_;  bus2.raddr = LD'(ra); bus2.clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 64'h0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_rd(input logic [63:0] d);
    q1.push_back('{data: d, cyc: cyc + 1});
    q2.push_back('{data: d, cyc: cyc + 2});
  endtask

  task automatic wr(input int a, input logic [63:0] d, input logic [7:0] be);
    drive(1'b1, a, d, be, 1'b0, 0, 1'b0);
    step();
    idle();
  endtask

  task automatic rd(input int a, input logic [63:0] d);
    drive(1'b0, 0, 64'h0, 8'h00, 1'b1, a, 1'b0);
    expect_rd(d);
    step();
    idle();
  endtask

  task automatic wait_clear(input string name);
    int n1 = 0;
    int n2 = 0;
    int n  = 0;
    while ((bus1.busy || bus2.busy) && n < 200) begin
      if (bus1.busy) n1++;
      if (bus2.busy) n2++;
      step();
      n++;
    end
    chk({name, " busy cycles lat1"}, 64'(n1), 64'd16);
    chk({name, " busy cycles lat2"}, 64'(n2), 64'd16);
  endtask

  // Pops and compares whenever either instance presents read data
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus1.rvalid) begin
          if (q1.size() == 0) begin
            n_chk++;
            $display("FAIL lat1 unexpected rvalid: got rdata %h expected no read", bus1.rdata);
          end else begin
            e = q1.pop_front();
            chk("lat1 rdata", bus1.rdata, e.data);
            chk("lat1 arrival cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (bus2.rvalid) begin
          if (q2.size() == 0) begin
            n_chk++;
            $display("FAIL lat2 unexpected rvalid: got rdata %h expected no read", bus2.rdata);
          end else begin
            e = q2.pop_front();
            chk("lat2 rdata", bus2.rdata, e.data);
            chk("lat2 arrival cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  endtask

  initial begin
    int t0;
    int n;
    n_chk  = 0;
    n_pass = 0;
    resetn = 1'b0;
    idle();
    fork
      monitor();
    join_none

    // Reset state and post-reset clear pass
    repeat (3) step();
    chk("reset busy lat1",   64'(bus1.busy),   64'd1);
    chk("reset busy lat2",   64'(bus2.busy),   64'd1);
    chk("reset rvalid lat1", 64'(bus1.rvalid), 64'd0);
    chk("reset rvalid lat2", 64'(bus2.rvalid), 64'd0);
    chk("reset rdata lat1",  bus1.rdata,       64'd0);
    chk("reset rdata lat2",  bus2.rdata,       64'd0);
    resetn = 1'b1;
    wait_clear("post-reset");
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 0, 64'h0, 8'h00, 1'b1, a, 1'b0);
      expect_rd(64'h0);
      step();
    end
    idle();

    // Byte enables
    wr(5, 64'h1122334455667788, 8'hFF);
    wr(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    wr(6, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    rd(5, 64'h11223344AAAAAAAA);
    rd(6, 64'h0);

    // Back-to-back reads
    for (int a = 1; a <= 4; a++) wr(a, 64'(a), 8'hFF);
    for (int a = 1; a <= 4; a++) begin
      drive(1'b0, 0, 64'h0, 8'h00, 1'b1, a, 1'b0);
      expect_rd(64'(a));
      step();
    end
    idle();

    // Same-address and different-address read/write in one cycle
    drive(1'b1, 7, 64'hFF, 8'h01, 1'b1, 7, 1'b0);
    expect_rd(RDW_EXP);
    step();
    idle();
    rd(7, 64'hFF);
    drive(1'b1, 8, 64'h77, 8'hFF, 1'b1, 1, 1'b0);
    expect_rd(64'h1);
    step();
    idle();
    rd(8, 64'h77);
    repeat (3) step();

    // Clear request with a read accepted in the same cycle, then accesses during the pass
    wr(0, 64'hDEAD, 8'hFF);
    drive(1'b0, 0, 64'h0, 8'h00, 1'b1, 0, 1'b1);
    expect_rd(64'hDEAD);
    step();
    idle();
    t0 = cyc;
    step();
    repeat (4) begin
      drive(1'b1, 0, 64'h55, 8'hFF, 1'b1, 0, 1'b0);
      step();
    end
    drive(1'b0, 0, 64'h0, 8'h00, 1'b0, 0, 1'b1);
    step();
    idle();
    n = 0;
    while (bus1.busy && n < 200) begin
      step();
      n++;
    end
    chk("clear pass length", 64'(cyc - t0), 64'd16);
    rd(0, 64'h0);
    rd(5, 64'h0);
    rd(3, 64'h0);
    repeat (3) step();

    // Reset in the middle of a clear pass
    wr(2, 64'h1234, 8'hFF);
    rd(2, 64'h1234);
    repeat (3) step();
    drive(1'b0, 0, 64'h0, 8'h00, 1'b0, 0, 1'b1);
    step();
    idle();
    repeat (8) step();
    resetn = 1'b0;
    #1;
    chk("mid-clear reset rvalid lat1", 64'(bus1.rvalid), 64'd0);
    chk("mid-clear reset rvalid lat2", 64'(bus2.rvalid), 64'd0);
    chk("mid-clear reset rdata lat1",  bus1.rdata,       64'd0);
    chk("mid-clear reset rdata lat2",  bus2.rdata,       64'd0);
    step();
    step();
    resetn = 1'b1;
    wait_clear("mid-clear reset");
    rd(2, 64'h0);
    wr(9, 64'hCAFE, 8'h03);
    rd(9, 64'hCAFE);

    repeat (5) step();
    chk("lat1 pending reads", 64'(q1.size()), 64'd0);
    chk("lat2 pending reads", 64'(q2.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
